arb_grant_skid_mux: RTL

// - Consumer stage directly downstream of round_robin_arbiter.
// - Uses the arbiter's one-hot grant vector to select the winning requester's payload.
// - Captures the payload with its requester index into a 2-entry skid buffer.
// - Presents the buffer head on a valid/ready output port.
// - Drives allow_o back into the arbiter's allow_i, so no grant is issued without buffer space.

---
 rtl/arb_grant_skid_mux.sv | 113 +++++++++++
 1 files changed

// File: rtl/arb_grant_skid_mux.sv
// Grant-steered payload mux feeding a 2-entry skid buffer.
// allow_o throttles the upstream arbiter so a grant always has a slot.
module arb_grant_skid_mux #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 64,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        gnt_i,
  output logic                      allow_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_W-1:0]         data_o,
  output logic [IDX_W-1:0]          idx_o,
  output logic [1:0]                count_o,
  output logic                      gnt_err_o,
  output logic                      ovf_err_o
);

  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [DATA_W-1:0] mem_data_q [2];
  logic [IDX_W-1:0]  mem_idx_q  [2];
  logic [DATA_W-1:0] data_q, data_d, sel_data;
  logic [IDX_W-1:0]  idx_q, idx_d, sel_idx;
  logic              gnt_err_q, ovf_err_q;
  logic              gnt_any, gnt_multi, gnt_one;
  logic              push, pop;

  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_i[k]) begin
        sel_data = sel_data | req_data_i[k*DATA_W +: DATA_W];
        sel_idx  = IDX_W'(k);
      end
    end
  end

  assign gnt_any   = |gnt_i;
  assign gnt_multi = |(gnt_i & (gnt_i - NUM_REQ'(1)));
  assign gnt_one   = gnt_any && !gnt_multi;

  // allow_o depends only on state so the arbiter loop stays acyclic
  assign allow_o = !rst_i && (count_q != 2'd2);
  assign valid_o = (count_q != 2'd0);
  assign push    = gnt_one && allow_o;
  assign pop     = valid_o && ready_i;

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Head is registered; a freshly pushed entry lands on the head
  // when the read pointer meets the write pointer after the pop.
  assign rd_nxt = rd_ptr_q ^ pop;

  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    if (count_d != 2'd0) begin
      if (push && (rd_nxt == wr_ptr_q)) begin
        data_d = sel_data;
        idx_d  = sel_idx;
      end else begin
        data_d = mem_data_q[rd_nxt];
        idx_d  = mem_idx_q[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q       <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_idx_q[0]  <= '0;
      mem_idx_q[1]  <= '0;
      data_q        <= '0;
      idx_q         <= '0;
      gnt_err_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_nxt;
      data_q   <= data_d;
      idx_q    <= idx_d;
      if (push) begin
        mem_data_q[wr_ptr_q] <= sel_data;
        mem_idx_q[wr_ptr_q]  <= sel_idx;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (gnt_multi) gnt_err_q <= 1'b1;
      if (gnt_any && !allow_o) ovf_err_q <= 1'b1;
    end
  end

  assign data_o    = data_q;
  assign idx_o     = idx_q;
  assign count_o   = count_q;
  assign gnt_err_o = gnt_err_q;
  assign ovf_err_o = ovf_err_q;

endmodule
